ball_game_ctrl: RTL and testbench

Frame-rate game controller for the camera ball overlay. Once per frame it moves the ball, bounces it off the screen edges and counts camera hits inside the ball area. It keeps the score and remaining lives and drives `ball_x`, `ball_y` and `score` into the video display block. It sits in the pixel-clock domain, beside the display block: it consumes that block's `is_hit_area` and a per-pixel camera hit flag.

---
 rtl/ball_game_pkg.sv | 17 +
 rtl/ball_game_ctrl_hit_accumulator.sv | 38 +++
 rtl/ball_game_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_ball_game_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ball_game_pkg.sv
// Shared types and screen constants for the ball game controller.
package ball_game_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PLAY     = 2'd1,
        COOLDOWN = 2'd2,
        OVER     = 2'd3
    } game_state_t;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int BALL_SIZE = 20;
    localparam int SCORE_MAX = 99;
    localparam int HIT_CNT_W = 12;

endpackage

// File: rtl/ball_game_ctrl_hit_accumulator.sv
// Per-frame saturating count of camera hit pixels inside the ball box, with threshold compare.
module hit_accumulator
    import ball_game_pkg::*;
#(
    parameter int HIT_THRESH = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic frame_start,
    input  logic pixel_valid,
    input  logic is_hit_area,
    input  logic hit_pixel,
    output logic hit
);

    localparam logic [HIT_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [HIT_CNT_W-1:0] THRESH  = HIT_CNT_W'(HIT_THRESH);

    logic [HIT_CNT_W-1:0] cnt;
    logic                 qual;

    assign qual = pixel_valid & is_hit_area & hit_pixel;
    assign hit  = (cnt >= THRESH);

    // A qualifying pixel in the frame_start cycle already belongs to the new frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (!en)
            cnt <= '0;
        else if (frame_start)
            cnt <= {{(HIT_CNT_W-1){1'b0}}, qual};
        else if (qual && cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/ball_game_ctrl.sv
// Frame-rate ball game controller: movement, bounce, hit scoring, lives.
// Define BALL_SPEEDUP_EN to raise ball speed with score (SPEED + score/10, max 7).
module ball_game_ctrl
    import ball_game_pkg::*;
#(
    parameter int H_ACTIVE        = ball_game_pkg::H_ACTIVE,
    parameter int V_ACTIVE        = ball_game_pkg::V_ACTIVE,
    parameter int BALL_SIZE       = ball_game_pkg::BALL_SIZE,
    parameter int INIT_X          = 100,
    parameter int INIT_Y          = 80,
    parameter int SPEED           = 2,
    parameter int HIT_THRESH      = 64,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int LIVES_INIT      = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic       pixel_valid,
    input  logic       is_hit_area,
    input  logic       hit_pixel,
    input  logic       start_btn,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic [1:0] game_state,
    output logic       hit_pulse
);

    localparam logic signed [10:0] XMAX = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic signed [10:0] YMAX = 11'(V_ACTIVE - BALL_SIZE);

    game_state_t        state, state_nxt;
    logic               dir_x, dir_y;       // 0 = right / down
    logic [7:0]         cd_cnt;
    logic               start_prev;
    logic               hit_raw, hit, miss, start_rise, acc_en;
    logic signed [10:0] spd, nx, ny;

    logic [9:0] x_nxt, y_nxt;
    logic       dx_nxt, dy_nxt, pulse_nxt;
    logic [7:0] score_nxt, cd_nxt;
    logic [1:0] lives_nxt;

    assign acc_en = (state == PLAY) || (state == COOLDOWN);

    hit_accumulator #(.HIT_THRESH(HIT_THRESH)) u_hit_acc (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (acc_en),
        .frame_start (frame_start),
        .pixel_valid (pixel_valid),
        .is_hit_area (is_hit_area),
        .hit_pixel   (hit_pixel),
        .hit         (hit_raw)
    );

`ifdef BALL_SPEEDUP_EN
    logic [7:0] spd_sum;
    always_comb begin
        spd_sum = 8'(SPEED) + score / 8'd10;
        spd     = (spd_sum > 8'd7) ? 11'sd7 : $signed({3'b000, spd_sum});
    end
`else
    assign spd = 11'(SPEED);
`endif

    assign nx = dir_x ? ($signed({1'b0, ball_x}) - spd) : ($signed({1'b0, ball_x}) + spd);
    assign ny = dir_y ? ($signed({1'b0, ball_y}) - spd) : ($signed({1'b0, ball_y}) + spd);

    assign hit        = hit_raw && (state == PLAY);
    assign miss       = (ny > YMAX) && !hit;
    assign start_rise = start_btn && !start_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_btn) state_nxt = PLAY;
            PLAY:     if (frame_start) begin
                          if (hit)                      state_nxt = COOLDOWN;
                          else if (miss && lives == 2'd1) state_nxt = OVER;
                      end
            COOLDOWN: if (frame_start) begin
                          if (miss && lives == 2'd1)    state_nxt = OVER;
                          else if (cd_cnt <= 8'd1)      state_nxt = PLAY;
                      end
            OVER:     if (start_rise) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Edge contact on x bounces immediately; the bottom edge only counts as a miss once crossed.
    always_comb begin
        x_nxt     = ball_x;
        y_nxt     = ball_y;
        dx_nxt    = dir_x;
        dy_nxt    = dir_y;
        score_nxt = score;
        lives_nxt = lives;
        cd_nxt    = cd_cnt;
        pulse_nxt = 1'b0;
        case (state)
            IDLE: begin
                x_nxt = 10'(INIT_X);
                y_nxt = 10'(INIT_Y);
                if (start_btn) begin
                    score_nxt = '0;
                    lives_nxt = 2'(LIVES_INIT);
                    dx_nxt    = 1'b0;
                    dy_nxt    = 1'b0;
                end
            end
            PLAY, COOLDOWN: if (frame_start) begin
                if (nx <= 11'sd0) begin
                    x_nxt  = '0;
                    dx_nxt = ~dir_x;
                end else if (nx >= XMAX) begin
                    x_nxt  = XMAX[9:0];
                    dx_nxt = ~dir_x;
                end else begin
                    x_nxt = nx[9:0];
                end

                if (ny < 11'sd0) begin
                    y_nxt  = '0;
                    dy_nxt = 1'b0;
                end else if (ny > YMAX) begin
                    if (hit) begin
                        y_nxt = YMAX[9:0];
                    end else begin
                        lives_nxt = lives - 2'd1;
                        x_nxt     = 10'(INIT_X);
                        y_nxt     = 10'(INIT_Y);
                        dx_nxt    = 1'b0;
                        dy_nxt    = 1'b0;
                    end
                end else begin
                    y_nxt = ny[9:0];
                end

                if (hit) begin
                    score_nxt = (score >= 8'(SCORE_MAX)) ? 8'(SCORE_MAX) : score + 8'd1;
                    dy_nxt    = 1'b1;
                    pulse_nxt = 1'b1;
                    cd_nxt    = 8'(COOLDOWN_FRAMES);
                end else if (state == COOLDOWN && cd_cnt != 8'd0) begin
                    cd_nxt = cd_cnt - 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ball_x     <= 10'(INIT_X);
            ball_y     <= 10'(INIT_Y);
            dir_x      <= 1'b0;
            dir_y      <= 1'b0;
            score      <= '0;
            lives      <= 2'(LIVES_INIT);
            cd_cnt     <= '0;
            hit_pulse  <= 1'b0;
            start_prev <= 1'b0;
        end else begin
            ball_x     <= x_nxt;
            ball_y     <= y_nxt;
            dir_x      <= dx_nxt;
            dir_y      <= dy_nxt;
            score      <= score_nxt;
            lives      <= lives_nxt;
            cd_cnt     <= cd_nxt;
            hit_pulse  <= pulse_nxt;
            start_prev <= start_btn;
        end
    end

    assign game_state = state;

endmodule

// File: tb/tb_ball_game_ctrl.sv
// Directed self-checking bench for ball_game_ctrl (default parameters).
module tb_ball_game_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_start, pixel_valid, is_hit_area, hit_pixel, start_btn;
    logic [9:0] ball_x, ball_y;
    logic [7:0] score;
    logic [1:0] lives, game_state;
    logic       hit_pulse;

    int n_cmp = 0;
    int n_err = 0;

    ball_game_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .pixel_valid (pixel_valid),
        .is_hit_area (is_hit_area),
        .hit_pixel   (hit_pixel),
        .start_btn   (start_btn),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .score       (score),
        .lives       (lives),
        .game_state  (game_state),
        .hit_pulse   (hit_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // hits qualifying pixels, two non-qualifying ones, then the frame_start cycle
    task automatic frame(input int hits);
        for (int i = 0; i < hits; i++) begin
            pixel_valid = 1'b1; is_hit_area = 1'b1; hit_pixel = 1'b1;
            tick();
        end
        pixel_valid = 1'b0; is_hit_area = 1'b1; hit_pixel = 1'b1;
        tick();
        pixel_valid = 1'b1; is_hit_area = 1'b0;
        tick();
        pixel_valid = 1'b0; hit_pixel = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        int px;
        reset_n = 1'b0;
        frame_start = 1'b0; pixel_valid = 1'b0; is_hit_area = 1'b0;
        hit_pixel = 1'b0; start_btn = 1'b0;
        repeat (3) tick();
        chk("rst_x", ball_x, 100);
        chk("rst_y", ball_y, 80);
        chk("rst_score", score, 0);
        chk("rst_lives", lives, 3);
        chk("rst_state", game_state, 0);
        chk("rst_pulse", hit_pulse, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        start_btn = 1'b1;
        tick();
        chk("start_state", game_state, 1);
        repeat (5) frame(0);
        chk("run_x", ball_x, 110);
        chk("run_y", ball_y, 90);
        chk("run_score", score, 0);
        chk("run_state", game_state, 1);

        frame(64);
        chk("hit_pulse", hit_pulse, 1);
        chk("hit_score", score, 1);
        chk("hit_state", game_state, 2);
        chk("hit_y", ball_y, 92);
        tick();
        chk("hit_pulse_clr", hit_pulse, 0);
        repeat (14) frame(100);
        chk("cd_state", game_state, 2);
        chk("cd_score", score, 1);
        frame(100);
        chk("cd_done_state", game_state, 1);
        chk("cd_done_score", score, 1);
        chk("cd_y", ball_y, 62);
        chk("cd_x", ball_x, 142);

        frame(63);
        chk("thr63_pulse", hit_pulse, 0);
        chk("thr63_score", score, 1);
        chk("thr63_state", game_state, 1);
        chk("thr63_y", ball_y, 60);

        for (int i = 0; i < 400 && lives == 2'd3; i++) frame(0);
        chk("miss1_lives", lives, 2);
        chk("miss1_x", ball_x, 100);
        chk("miss1_y", ball_y, 80);
        chk("miss1_state", game_state, 1);
        for (int i = 0; i < 400 && lives == 2'd2; i++) frame(0);
        chk("miss2_lives", lives, 1);
        for (int i = 0; i < 400 && game_state != 2'd3; i++) frame(0);
        chk("over_state", game_state, 3);
        chk("over_lives", lives, 0);
        chk("over_score", score, 1);
        frame(64);
        chk("over_frozen_x", ball_x, 100);
        chk("over_frozen_y", ball_y, 80);
        chk("over_hold_score", score, 1);
        chk("over_no_pulse", hit_pulse, 0);
        repeat (3) tick();
        chk("over_level_held", game_state, 3);

        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        tick();
        chk("restart_idle", game_state, 0);
        tick();
        chk("restart_play", game_state, 1);
        chk("restart_score", score, 0);
        chk("restart_lives", lives, 3);

        for (int i = 0; i < 400 && ball_y != 10'd460; i++) frame(0);
        chk("hm_pre_y", ball_y, 460);
        frame(64);
        chk("hm_score", score, 1);
        chk("hm_lives", lives, 3);
        chk("hm_state", game_state, 2);
        chk("hm_y", ball_y, 460);
        frame(0);
        chk("hm_y_up", ball_y, 458);

        for (int i = 0; i < 300 && ball_x != 10'd618; i++) frame(0);
        chk("xb_pre", ball_x, 618);
        frame(0);
        chk("xb_edge", ball_x, 620);
        frame(0);
        chk("xb_back", ball_x, 618);
        chk("xb_state", game_state, 1);

        for (int i = 0; i < 120 && score < 8'd99; i++) begin
            frame(64);
`ifdef BALL_SPEEDUP_EN
            if (score == 8'd30) begin
                px = ball_x;
                frame(0);
                chk("speedup_dx", (px - ball_x == 5 || ball_x - px == 5 ||
                                   ball_x == 10'd0 || ball_x == 10'd620) ? 1 : 0, 1);
            end
`endif
            repeat (15) frame(0);
        end
        chk("sat_reach", score, 99);
        chk("sat_state", game_state, 1);
        frame(64);
        chk("sat_pulse", hit_pulse, 1);
        chk("sat_score", score, 99);

        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_state", game_state, 0);
        chk("arst_score", score, 0);
        chk("arst_x", ball_x, 100);
        chk("arst_lives", lives, 3);
        tick();
        reset_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
